// File: rtl/bg_pixel_fifo_if.sv
// Fetcher-to-FIFO push bus plus the FIFO's pixel stream toward the mixer.
// The fetcher side (or a bench) uses master and the FIFO uses slave.
interface bg_pixel_fifo_if #(
   parameter int X_MAX = 160
);
   localparam int XW = $clog2(X_MAX);

   // Handshake: valid_pixels_in is a level strobe. A row is taken only on a
   // tclk_in edge where empty_out is high. pixel_valid_out is a one-clock
   // pulse with no back-pressure from the consumer.
   logic                valid_pixels_in;
   logic [7:0][1:0]     pixels_in;
   logic                empty_out;
   logic                pixel_valid_out;
   logic [1:0]          pixel_out;
   logic [XW-1:0]       pixel_x_out;
   logic                line_done_out;

   modport master (
      output valid_pixels_in,
      output pixels_in,
      input  empty_out,
      input  pixel_valid_out,
      input  pixel_out,
      input  pixel_x_out,
      input  line_done_out
   );

   modport slave (
      input  valid_pixels_in,
      input  pixels_in,
      output empty_out,
      output pixel_valid_out,
      output pixel_out,
      output pixel_x_out,
      output line_done_out
   );
endinterface

// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO: takes 8-pixel tile rows, shifts one colour index per
// T-cycle, discards SCX fine-scroll pixels at line start and stops at X_MAX.
module bg_pixel_fifo #(
   parameter int X_MAX = 160
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               tclk_in,
   input  logic               line_start_in,
   input  logic [7:0]         SCX_in,
   input  logic               window_flush_in,
   input  logic               stall_in,
   bg_pixel_fifo_if.slave     fifo_if
);
   localparam int XW = $clog2(X_MAX);
   localparam logic [XW-1:0] X_LAST = XW'(X_MAX - 1);

   logic [7:0][1:0] store_q, store_d;
   logic [3:0]      count_q, count_d;
   logic [2:0]      discard_q, discard_d;
   logic [XW-1:0]   x_q, x_d;
   logic            done_q, done_d;
   logic            pv_q, pv_d;
   logic [1:0]      pix_q, pix_d;
   logic [XW-1:0]   pix_x_q, pix_x_d;

   logic            do_push;
   logic            do_pop;
   logic            unused_scx;

   assign unused_scx = ^SCX_in[7:3];

   // A push needs an empty FIFO, so push and pop are mutually exclusive.
   assign do_push = tclk_in && fifo_if.valid_pixels_in && (count_q == 4'd0);
   assign do_pop  = tclk_in && (count_q != 4'd0) && !stall_in && !done_q;

   always_comb begin
      store_d   = store_q;
      count_d   = count_q;
      discard_d = discard_q;
      x_d       = x_q;
      done_d    = done_q;
      pv_d      = 1'b0;
      pix_d     = pix_q;
      pix_x_d   = pix_x_q;

      if (line_start_in) begin
         count_d   = 4'd0;
         x_d       = '0;
         discard_d = SCX_in[2:0];
         done_d    = 1'b0;
      end else if (window_flush_in) begin
         count_d = 4'd0;
      end else if (do_push) begin
         store_d = fifo_if.pixels_in;
         count_d = 4'd8;
      end else if (do_pop) begin
         for (int i = 0; i < 7; i++) begin
            store_d[i] = store_q[i+1];
         end
         store_d[7] = 2'd0;
         count_d    = count_q - 4'd1;
         if (discard_q != 3'd0) begin
            discard_d = discard_q - 3'd1;
         end else begin
            pv_d    = 1'b1;
            pix_d   = store_q[0];
            pix_x_d = x_q;
            // x holds at the last column; done_q blocks further pops anyway.
            if (x_q == X_LAST) begin
               done_d = 1'b1;
            end else begin
               x_d = x_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         store_q   <= '0;
         count_q   <= 4'd0;
         discard_q <= 3'd0;
         x_q       <= '0;
         done_q    <= 1'b0;
         pv_q      <= 1'b0;
         pix_q     <= 2'd0;
         pix_x_q   <= '0;
      end else begin
         store_q   <= store_d;
         count_q   <= count_d;
         discard_q <= discard_d;
         x_q       <= x_d;
         done_q    <= done_d;
         pv_q      <= pv_d;
         pix_q     <= pix_d;
         pix_x_q   <= pix_x_d;
      end
   end

   assign fifo_if.empty_out       = (count_q == 4'd0);
   assign fifo_if.pixel_valid_out = pv_q;
   assign fifo_if.pixel_out       = pix_q;
   assign fifo_if.pixel_x_out     = pix_x_q;
   assign fifo_if.line_done_out   = done_q;
endmodule

// File: tb/tb_bg_pixel_fifo.sv
// Directed bench for bg_pixel_fifo: expected {x, pixel} pairs are queued as
// stimulus is issued and a negedge monitor compares every emitted pixel.
module tb_bg_pixel_fifo;
   localparam int X_MAX = 160;
   localparam int XW    = $clog2(X_MAX);
   localparam int W     = XW + 2;

   logic       clk_in = 1'b0;
   logic       rst_n_in;
   logic       tclk_in;
   logic       line_start_in;
   logic [7:0] SCX_in;
   logic       window_flush_in;
   logic       stall_in;

   bg_pixel_fifo_if #(.X_MAX(X_MAX)) bus ();

   bg_pixel_fifo #(.X_MAX(X_MAX)) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .tclk_in         (tclk_in),
      .line_start_in   (line_start_in),
      .SCX_in          (SCX_in),
      .window_flush_in (window_flush_in),
      .stall_in        (stall_in),
      .fifo_if         (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_in = ~clk_in;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   logic [W-1:0] exp_q[$];

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if (rst_n_in === 1'b1 && bus.pixel_valid_out === 1'b1) begin
         pulses++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pixel actual=x%0d/p%0d required=none",
                     bus.pixel_x_out, bus.pixel_out);
         end else begin
            check("pixel", 32'({bus.pixel_x_out, bus.pixel_out}), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic tcyc(input logic v, input logic s);
      bus.valid_pixels_in = v;
      stall_in = s;
      tclk_in = 1'b1;
      tick();
      tclk_in = 1'b0;
      tick();
   endtask

   task automatic line_start(input logic [7:0] scx);
      SCX_in = scx;
      line_start_in = 1'b1;
      tick();
      line_start_in = 1'b0;
      tick();
   endtask

   task automatic push_row(input logic [15:0] row);
      bus.pixels_in = row;
      tcyc(1'b1, 1'b0);
      bus.valid_pixels_in = 1'b0;
   endtask

   task automatic expect_pix(input int x, input logic [1:0] p);
      exp_q.push_back({x[XW-1:0], p});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] row;
      int base;

      rst_n_in = 1'b0;
      tclk_in = 1'b0;
      line_start_in = 1'b0;
      SCX_in = 8'd0;
      window_flush_in = 1'b0;
      stall_in = 1'b0;
      bus.valid_pixels_in = 1'b0;
      bus.pixels_in = '0;
      repeat (3) tick();
      check("rst_empty", 32'(bus.empty_out), 32'd1);
      check("rst_valid", 32'(bus.pixel_valid_out), 32'd0);
      rst_n_in = 1'b1;
      tick();

      // 1: asynchronous reset mid-line with a pixel on the outputs
      line_start(8'd0);
      row = 16'h1BE4;  // pixels 0,1,2,3,3,2,1,0
      push_row(row);
      for (int i = 0; i < 3; i++) begin
         expect_pix(i, row[2*i +: 2]);
         tcyc(1'b0, 1'b0);
      end
      tclk_in = 1'b1;
      tick();
      tclk_in = 1'b0;
      check("pre_rst_x", 32'(bus.pixel_x_out), 32'd3);
      check("pre_rst_pix", 32'(bus.pixel_out), 32'd3);
      check("pre_rst_empty", 32'(bus.empty_out), 32'd0);
      #1 rst_n_in = 1'b0;
      #1;
      check("async_rst_valid", 32'(bus.pixel_valid_out), 32'd0);
      check("async_rst_pix", 32'(bus.pixel_out), 32'd0);
      check("async_rst_x", 32'(bus.pixel_x_out), 32'd0);
      check("async_rst_empty", 32'(bus.empty_out), 32'd1);
      check("async_rst_done", 32'(bus.line_done_out), 32'd0);
      tick();
      rst_n_in = 1'b1;
      tick();

      // 2: SCX=0, one row, eight pops
      line_start(8'd0);
      push_row(row);
      check("t2_empty_after_push", 32'(bus.empty_out), 32'd0);
      for (int i = 0; i < 8; i++) begin
         expect_pix(i, row[2*i +: 2]);
         tcyc(1'b0, 1'b0);
         if (i == 6) check("t2_not_empty_7", 32'(bus.empty_out), 32'd0);
      end
      check("t2_empty_after_8", 32'(bus.empty_out), 32'd1);
      check("t2_drain", 32'(exp_q.size()), 32'd0);

      // 3: SCX=0x0B discards three pixels
      line_start(8'h0B);
      row = 16'hE4E4;  // pixels 0,1,2,3,0,1,2,3
      base = pulses;
      push_row(row);
      for (int i = 3; i < 8; i++) expect_pix(i - 3, row[2*i +: 2]);
      repeat (8) tcyc(1'b0, 1'b0);
      check("t3_pulse_count", 32'(pulses - base), 32'd5);
      check("t3_drain", 32'(exp_q.size()), 32'd0);

      // 4: stall with fetcher valid held high
      line_start(8'd0);
      row = 16'h9C63;
      push_row(row);
      for (int i = 0; i < 2; i++) begin
         expect_pix(i, row[2*i +: 2]);
         tcyc(1'b0, 1'b0);
      end
      base = pulses;
      bus.pixels_in = 16'h5555;
      repeat (6) tcyc(1'b1, 1'b1);
      check("t4_stall_no_pulse", 32'(pulses - base), 32'd0);
      check("t4_stall_not_empty", 32'(bus.empty_out), 32'd0);
      for (int i = 2; i < 8; i++) begin
         expect_pix(i, row[2*i +: 2]);
         tcyc(1'b0, 1'b0);
      end
      check("t4_empty_after", 32'(bus.empty_out), 32'd1);
      check("t4_drain", 32'(exp_q.size()), 32'd0);

      // 5: full line of 20 rows, then overflow row stays queued
      line_start(8'd0);
      base = pulses;
      for (int k = 0; k < 20; k++) begin
         row = 16'h1BE4 ^ 16'(k * 16'h0357);
         push_row(row);
         for (int i = 0; i < 8; i++) begin
            if (k == 19 && i == 7) check("t5_done_before_last", 32'(bus.line_done_out), 32'd0);
            expect_pix(k * 8 + i, row[2*i +: 2]);
            tcyc(1'b0, 1'b0);
         end
      end
      check("t5_pulse_count", 32'(pulses - base), 32'd160);
      check("t5_done", 32'(bus.line_done_out), 32'd1);
      check("t5_last_x", 32'(bus.pixel_x_out), 32'd159);
      base = pulses;
      push_row(16'hFFFF);
      repeat (8) tcyc(1'b0, 1'b0);
      check("t5_no_pops_after_done", 32'(pulses - base), 32'd0);
      check("t5_filled", 32'(bus.empty_out), 32'd0);
      check("t5_done_held", 32'(bus.line_done_out), 32'd1);
      line_start(8'd0);
      check("t5_done_cleared", 32'(bus.line_done_out), 32'd0);
      check("t5_ls_empty", 32'(bus.empty_out), 32'd1);

      // 6: window flush with four pixels queued, flush overrides a tclk
      row = 16'h27D8;
      push_row(row);
      for (int i = 0; i < 4; i++) begin
         expect_pix(i, row[2*i +: 2]);
         tcyc(1'b0, 1'b0);
      end
      check("t6_pre_flush_not_empty", 32'(bus.empty_out), 32'd0);
      base = pulses;
      window_flush_in = 1'b1;
      tclk_in = 1'b1;
      tick();
      window_flush_in = 1'b0;
      tclk_in = 1'b0;
      tick();
      check("t6_flush_empty", 32'(bus.empty_out), 32'd1);
      check("t6_flush_no_pulse", 32'(pulses - base), 32'd0);
      row = 16'hB1C6;
      push_row(row);
      for (int i = 0; i < 8; i++) begin
         expect_pix(4 + i, row[2*i +: 2]);
         tcyc(1'b0, 1'b0);
      end
      repeat (4) tick();
      check("final_drain", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
